// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit display source arbiter.
package disp_pkg;

  typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} owner_e;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned DIGIT_W   = 4;
  localparam logic [3:0]  BLANK_ALL = 4'hF;

  // Leading-zero mask from the top digit down; the last digit always stays lit.
  function automatic logic [DIGITS-1:0] lz_blank(input logic [DIGITS*DIGIT_W-1:0] d);
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      run         = run & (d[i*DIGIT_W +: DIGIT_W] == '0);
      lz_blank[i] = run;
    end
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, synchronous clear.
module disp_tick_gen #(
  parameter int unsigned TICK_DIV = 16000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/disp_src_arbiter.sv
// Arbitrates the display between persistent source A and timed overlay source B.
// Optional DISP_LZ_BLANK_EN blanks leading zero digits while a source is shown.
module disp_src_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned TICK_DIV = 16000,
  parameter int unsigned HOLD_MS  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [15:0] b_data,
  output logic        b_ready,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [1:0]  owner
);

  localparam int unsigned HW = $clog2(HOLD_MS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);
  localparam logic [HW-1:0] HOLD_END  = HW'(HOLD_MS);

  state_e        state, state_n;
  logic [15:0]   a_shadow, a_shadow_n;
  logic [15:0]   b_shadow, b_shadow_n;
  logic          a_seen, a_seen_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [15:0]   digits_n;
  logic [3:0]    blank_n;
  logic [1:0]    owner_n;
  logic          a_xfer, b_xfer, tick;

  assign a_ready = rst;
  assign b_ready = rst;
  assign a_xfer  = a_valid & a_ready;
  assign b_xfer  = b_valid & b_ready;

  disp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (b_xfer),
    .tick (tick)
  );

  always_comb begin
    state_n    = state;
    a_shadow_n = a_shadow;
    b_shadow_n = b_shadow;
    a_seen_n   = a_seen;
    hold_n     = hold_cnt;

    if (a_xfer) begin
      a_shadow_n = a_data;
      a_seen_n   = 1'b1;
    end

    if (b_xfer) begin
      b_shadow_n = b_data;
      hold_n     = '0;
      state_n    = SHOW_B;
    end else begin
      case (state)
        IDLE:    if (a_xfer) state_n = SHOW_A;
        SHOW_A:  state_n = SHOW_A;
        SHOW_B: begin
          if (tick) begin
            if (hold_cnt != HOLD_END) hold_n = hold_cnt + 1'b1;
            // an A arriving on the expiry cycle is shown straight away
            if (hold_cnt == HOLD_LAST) state_n = a_seen_n ? SHOW_A : IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state so they land one edge after the event.
  always_comb begin
    digits_n = '0;
    owner_n  = OWN_NONE;
    blank_n  = BLANK_ALL;
    case (state_n)
      SHOW_A: begin
        digits_n = a_shadow_n;
        owner_n  = OWN_A;
      end
      SHOW_B: begin
        digits_n = b_shadow_n;
        owner_n  = OWN_B;
      end
      default: ;
    endcase
    if (state_n != IDLE) begin
`ifdef DISP_LZ_BLANK_EN
      blank_n = lz_blank(digits_n);
`else
      blank_n = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      a_shadow <= '0;
      b_shadow <= '0;
      a_seen   <= 1'b0;
      hold_cnt <= '0;
      digits   <= '0;
      blank    <= BLANK_ALL;
      owner    <= OWN_NONE;
    end else begin
      state    <= state_n;
      a_shadow <= a_shadow_n;
      b_shadow <= b_shadow_n;
      a_seen   <= a_seen_n;
      hold_cnt <= hold_n;
      digits   <= digits_n;
      blank    <= blank_n;
      owner    <= owner_n;
    end
  end

endmodule

// File: tb/tb_disp_src_arbiter.sv
// Scoreboard bench for disp_src_arbiter with TICK_DIV=4, HOLD_MS=3 (12-cycle hold).
module tb_disp_src_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [1:0]  owner;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic [1:0]  own;
    logic [15:0] dig;
    logic [3:0]  blk;
    logic        chk_dig;
  } exp_t;

  exp_t exp_q[$];

  disp_src_arbiter #(.TICK_DIV(4), .HOLD_MS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .digits  (digits),
    .blank   (blank),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_blank(input logic [1:0] own, input logic [15:0] d);
    logic [3:0] b;
    if (own == 2'd0) return 4'hF;
    b = 4'h0;
`ifdef DISP_LZ_BLANK_EN
    if (d[15:12] == 4'd0) begin
      b[3] = 1'b1;
      if (d[11:8] == 4'd0) begin
        b[2] = 1'b1;
        if (d[7:4] == 4'd0) b[1] = 1'b1;
      end
    end
`endif
    return b;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic av, input logic [15:0] ad,
                      input logic bv, input logic [15:0] bd,
                      input logic [1:0] own, input logic [15:0] dig,
                      input logic chk_dig);
    exp_t e;
    @(negedge clk);
    a_valid = av; a_data = ad;
    b_valid = bv; b_data = bd;
    e.own = own; e.dig = dig; e.blk = exp_blank(own, dig); e.chk_dig = chk_dig;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int unsigned n, input logic [1:0] own,
                      input logic [15:0] dig, input logic chk_dig);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 16'h0, own, dig, chk_dig);
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("owner", owner, e.own);
        chk("blank", blank, e.blk);
        if (e.chk_dig) chk("digits", digits, e.dig);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #12;
    chk("rst_owner", owner, 2'd0);
    chk("rst_blank", blank, 4'hF);
    chk("rst_digits", digits, 16'h0);
    chk("rst_a_ready", a_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("a_ready", a_ready, 1'b1);
    chk("b_ready", b_ready, 1'b1);

    // 1. idle with no requests
    idle(6, 2'd0, 16'h0, 1'b1);

    // 2. A 0x1234
    step(1'b1, 16'h1234, 1'b0, 16'h0, 2'd1, 16'h1234, 1'b1);
    idle(3, 2'd1, 16'h1234, 1'b1);

    // 3. B 0x0E00 over A: 12 cycles of B then back to A
    step(1'b0, 16'h0, 1'b1, 16'h0E00, 2'd2, 16'h0E00, 1'b1);
    idle(11, 2'd2, 16'h0E00, 1'b1);
    idle(3, 2'd1, 16'h1234, 1'b1);

    // 4. simultaneous A and B: B wins, new A appears afterwards
    step(1'b1, 16'h5555, 1'b1, 16'h0007, 2'd2, 16'h0007, 1'b1);
    idle(11, 2'd2, 16'h0007, 1'b1);
    idle(3, 2'd1, 16'h5555, 1'b1);
    drain();

    // 5. reset, then B without A, re-triggered at hold cycle 8
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    step(1'b0, 16'h0, 1'b1, 16'h0003, 2'd2, 16'h0003, 1'b1);
    idle(7, 2'd2, 16'h0003, 1'b1);
    step(1'b0, 16'h0, 1'b1, 16'h0009, 2'd2, 16'h0009, 1'b1);
    idle(11, 2'd2, 16'h0009, 1'b1);
    idle(4, 2'd0, 16'h0, 1'b0);

    // A arriving while B holds is kept back until expiry
    step(1'b0, 16'h0, 1'b1, 16'h0100, 2'd2, 16'h0100, 1'b1);
    idle(4, 2'd2, 16'h0100, 1'b1);
    step(1'b1, 16'h0042, 1'b0, 16'h0, 2'd2, 16'h0100, 1'b1);
    idle(6, 2'd2, 16'h0100, 1'b1);
    idle(3, 2'd1, 16'h0042, 1'b1);
    drain();

    // 6. A shown, B overlay, asynchronous reset mid-hold
    step(1'b1, 16'h1111, 1'b0, 16'h0, 2'd1, 16'h1111, 1'b1);
    step(1'b0, 16'h0, 1'b1, 16'h0E00, 2'd2, 16'h0E00, 1'b1);
    idle(4, 2'd2, 16'h0E00, 1'b1);
    drain();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_owner", owner, 2'd0);
    chk("async_blank", blank, 4'hF);
    chk("async_digits", digits, 16'h0);
    @(negedge clk); rst = 1'b1;
    // stale A must not reappear
    idle(15, 2'd0, 16'h0, 1'b1);

    // leading-zero pattern 0x0042 and all-zero value
    step(1'b1, 16'h0042, 1'b0, 16'h0, 2'd1, 16'h0042, 1'b1);
    idle(1, 2'd1, 16'h0042, 1'b1);
    step(1'b1, 16'h0000, 1'b0, 16'h0, 2'd1, 16'h0000, 1'b1);
    idle(1, 2'd1, 16'h0000, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
